// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported, variable-latency memory between instruction fetch and data access.
// Define ARB_STARVE_GUARD_EN to let fetch win a tie after MAX_WAIT consecutive lost ties.
module mem_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_stall,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [2:0]        dm_funct3,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_valid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [2:0]        mem_funct3,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              err_spurious_ack
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_IF_ACC,
        ST_DM_ACC,
        ST_RESP
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              w_grant_if;
    logic              w_grant_dm;
    logic              w_force_if;
    logic              w_mem_req_nxt;
    logic              w_if_valid_nxt;
    logic              w_dm_valid_nxt;

    logic              r_mem_req;
    logic              r_if_valid;
    logic              r_dm_valid;
    logic              r_we;
    logic [2:0]        r_funct3;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_dm_rdata;
    logic              r_err;

`ifdef ARB_STARVE_GUARD_EN
    localparam int CW = ($clog2(MAX_WAIT + 1) > 3) ? $clog2(MAX_WAIT + 1) : 3;
    logic [CW-1:0] r_wait_cnt;
    logic          w_tie_lost;

    assign w_force_if = (r_wait_cnt == CW'(MAX_WAIT));
    assign w_tie_lost = w_grant_dm && if_req;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wait_cnt <= '0;
        end else if (w_grant_if) begin
            r_wait_cnt <= '0;
        end else if (w_tie_lost && (r_wait_cnt != '1)) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end
`else
    assign w_force_if = 1'b0;
`endif

    // Arbitration only happens in IDLE; data wins unless the guard forces fetch.
    always_comb begin
        w_grant_if = 1'b0;
        w_grant_dm = 1'b0;
        if (r_state == ST_IDLE) begin
            if (dm_req && !(if_req && w_force_if)) begin
                w_grant_dm = 1'b1;
            end else if (if_req) begin
                w_grant_if = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_dm) begin
                    w_next = ST_DM_ACC;
                end else if (w_grant_if) begin
                    w_next = ST_IF_ACC;
                end
            end
            ST_IF_ACC, ST_DM_ACC: begin
                if (mem_ack) begin
                    w_next = ST_RESP;
                end
            end
            ST_RESP: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs, decoded from the upcoming state.
    always_comb begin
        w_mem_req_nxt  = (w_next == ST_IF_ACC) || (w_next == ST_DM_ACC);
        w_if_valid_nxt = (r_state == ST_IF_ACC) && mem_ack;
        w_dm_valid_nxt = (r_state == ST_DM_ACC) && mem_ack;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mem_req  <= 1'b0;
            r_if_valid <= 1'b0;
            r_dm_valid <= 1'b0;
            r_we       <= 1'b0;
            r_funct3   <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_if_rdata <= '0;
            r_dm_rdata <= '0;
            r_err      <= 1'b0;
        end else begin
            r_mem_req  <= w_mem_req_nxt;
            r_if_valid <= w_if_valid_nxt;
            r_dm_valid <= w_dm_valid_nxt;
            if (w_grant_dm) begin
                r_addr   <= dm_addr;
                r_we     <= dm_we;
                r_funct3 <= dm_funct3;
                r_wdata  <= dm_wdata;
            end else if (w_grant_if) begin
                r_addr   <= if_addr;
                r_we     <= 1'b0;
                r_funct3 <= 3'b010;
                r_wdata  <= '0;
            end
            if (w_if_valid_nxt) begin
                r_if_rdata <= mem_rdata;
            end
            if (w_dm_valid_nxt && !r_we) begin
                r_dm_rdata <= mem_rdata;
            end
            if (mem_ack && !r_mem_req) begin
                r_err <= 1'b1;
            end
        end
    end

    assign mem_req          = r_mem_req;
    assign mem_we           = r_we;
    assign mem_funct3       = r_funct3;
    assign mem_addr         = r_addr;
    assign mem_wdata        = r_wdata;
    assign if_valid         = r_if_valid;
    assign if_rdata         = r_if_rdata;
    assign dm_valid         = r_dm_valid;
    assign dm_rdata         = r_dm_rdata;
    assign err_spurious_ack = r_err;
    assign if_stall         = if_req & ~r_if_valid;
    assign dm_stall         = dm_req & ~r_dm_valid;

endmodule
